muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multiply/divide execution unit with HI/LO registers for the pipelined MIPS core. It sits in the EX stage beside the ALU and accepts mult/multu/div/divu issues plus mthi/mtlo writes. It drives the `busy` signal that the stall controller consumes: while `busy` or `start` is high, the controller holds any muldiv-class instruction in ID. HI/LO are always readable combinationally for mfhi/mflo.

## Interface

Parameters:
- MUL_CYCLES, 5, number of busy cycles for mult/multu; legal range is 1 or more.
- DIV_CYCLES, 10, number of busy cycles for div/divu; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue strobe for a mult/multu/div/divu in EX (the `ifmuldiv` qualifier).
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu. Sampled only with `start`.
- a  in  32  rs operand (multiplicand or dividend), already forwarded.
- b  in  32  rt operand (multiplier or divisor), already forwarded.
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  32  mthi/mtlo data (forwarded rs).
- busy  out  1  registered; high while an operation is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation

- Internal state is IDLE or RUN, plus a down-counter `cnt` of 4 or more bits, wide enough for max(MUL_CYCLES, DIV_CYCLES).
- Operands and `op` are latched at the accepting edge. Later changes on `a`, `b` or `op` have no effect on the operation in flight.
- Start acceptance:
  - A `start` in IDLE is accepted. The unit moves to RUN and loads `cnt` with MUL_CYCLES or DIV_CYCLES.
  - A `start` in RUN is ignored. The stall controller guarantees this never happens; the bench checks it is harmless.
- In RUN, `cnt` decrements every edge. On the edge where `cnt` goes 1→0:
  - HI/LO load the result.
  - The state returns to IDLE.
  - `busy` falls.
- Result encoding:
  - mult is a signed 32×32→64 product; multu is the unsigned product. HI = bits [63:32], LO = bits [31:0].
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero, and the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0x00000000.
  - Divisor 0 (div or divu): the full DIV_CYCLES busy period still runs, and at completion HI and LO keep their previous values.
- mthi/mtlo:
  - In IDLE with `start` low, `hi_we` loads `wdata` into HI and `lo_we` loads `wdata` into LO at the edge. Both enables may be high together.
  - `hi_we`/`lo_we` are ignored while `busy` is high or in a cycle where `start` is high, because start has priority.
- The datapath may be a single-cycle multiplier/divider whose result is held until `cnt` expires, or an iterative one. Only the cycle timing below is observable.

## Timing

- Reset:
  - Takes priority over everything.
  - At the reset edge: busy = 0, hi = 0, lo = 0, `cnt` = 0, state = IDLE.
  - A reset during RUN aborts the operation, and no result is written.
- Start accepted at edge E0: `busy` = 1 from just after E0 through edge E(N−1). At edge EN, hi/lo update and `busy` = 0, where N = MUL_CYCLES or DIV_CYCLES.
- `busy` is high for exactly N cycles per operation.
- Back-to-back issue: a new `start` is accepted in the first cycle `busy` is low, that is, at edge E(N+1) at the earliest.
- hi/lo outputs are the register values and have no combinational bypass. mfhi in the cycle after EN reads the new result.
- mthi/mtlo take effect at the sampling edge and are visible the following cycle.
- There is no other latency. `busy` never glitches because it is a flop output.

## Test plan

- **Reset value:** hold reset for 2 cycles, then release → busy = 0, hi = lo = 0x00000000. Then assert reset during RUN (start mult, reset at E2) → busy = 0 and hi/lo = 0 after that edge, with no later result write.
- **mult/multu:** a = 0xFFFFFFFF, b = 0x00000002.
  - op = 00 → after 5 busy cycles, hi = 0xFFFFFFFF and lo = 0xFFFFFFFE.
  - op = 01 → hi = 0x00000001 and lo = 0xFFFFFFFE.
  - In both cases busy is high for exactly 5 cycles.
- **div/divu:**
  - a = 0xFFFFFFF9 (−7), b = 2, op = 10 → after 10 busy cycles, lo = 0xFFFFFFFD and hi = 0xFFFFFFFF.
  - a = 7, b = 2, op = 11 → lo = 3, hi = 1.
  - a = 0x80000000, b = 0xFFFFFFFF, op = 10 → lo = 0x80000000, hi = 0.
- **Divide by zero:** preload hi = 0x11111111 and lo = 0x22222222 via mthi/mtlo, then divu with b = 0 → busy is high for 10 cycles, and afterwards hi/lo are unchanged.
- **Ignored requests:**
  - During a mult, pulse start (div) and hi_we/lo_we with wdata = 0xDEADBEEF → the mult result is unaffected and no write occurs.
  - After busy falls, lo_we with wdata = 0xDEADBEEF → lo = 0xDEADBEEF next cycle.
- **Back-to-back:** multu 3×4, then a start in the first cycle busy is low with divu 100/7 → lo = 12 after the first operation. Then busy goes high again for 10 cycles, ending with lo = 14 and hi = 2.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multiply/divide execution unit with HI/LO registers.
//
// Accepts mult/multu/div/divu issues and mthi/mtlo writes. The result is
// computed in one cycle at the accepting edge and held in a staging register
// until the busy period expires. Then it is committed to HI/LO.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        issue strobe for mult/multu/div/divu
//   op           00 mult, 01 multu, 10 div, 11 divu (sampled with start)
//   a, b         rs / rt operands
//   hi_we, lo_we mthi / mtlo write enables
//   wdata        mthi / mtlo data
//   busy         registered, high while an operation is in flight
//   hi, lo       HI / LO registers
//   dbg_state_o  FSM state for observation (0 = IDLE, 1 = RUN)
//
// Handshake: a start is accepted only on an edge where the unit is IDLE.
// busy rises right after that edge and stays high for exactly N cycles.
// N is MUL_CYCLES or DIV_CYCLES. HI/LO update on the edge where busy falls.
// A start seen while busy is dropped. mthi/mtlo are honoured only when the
// unit is IDLE and start is low.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbg_state_o
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          res_wr_q, res_wr_d;

  // Single-cycle datapath, evaluated on the live operands at the accept edge.
  logic [63:0] prod_s, prod_u;
  logic        sgn;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    sgn    = ~op[0];
    // Divide on magnitudes and fix the signs afterwards. This handles
    // 0x80000000 / -1 without overflow: the magnitude 0x80000000 negates
    // back to itself.
    a_mag  = (sgn && a[31]) ? (~a + 32'd1) : a;
    b_mag  = (sgn && b[31]) ? (~b + 32'd1) : b;
    q_mag  = (b == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag  = (b == 32'd0) ? 32'd0 : (a_mag % b_mag);
    div_q  = (sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    div_r  = (sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
          res_wr_d = 1'b1;
          if (!op[1]) begin
            res_hi_d = op[0] ? prod_u[63:32] : prod_s[63:32];
            res_lo_d = op[0] ? prod_u[31:0]  : prod_s[31:0];
          end else begin
            res_hi_d = div_r;
            res_lo_d = div_q;
            // A zero divisor still runs the full period but commits nothing.
            res_wr_d = (b != 32'd0);
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign busy        = busy_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = (state_q == RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi, lo;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;
  int n;

  muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue an operation. On return the accept edge has passed, and the
  // operands are scrambled to show they were latched.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
  endtask

  // Count the sampled cycles with busy high, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;

    // reset value
    step(); step();
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // reset during RUN aborts the operation
    issue(2'b00, 32'd3, 32'd4);
    chk("run_busy", {31'd0, busy}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    repeat (8) step();
    chk("abort_nowr_hi", hi, 32'h0);
    chk("abort_nowr_lo", lo, 32'h0);

    // mult / multu
    issue(2'b00, 32'hFFFFFFFF, 32'h00000002);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);

    issue(2'b01, 32'hFFFFFFFF, 32'h00000002);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // div / divu
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(2'b11, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_cycles", 32'(n), 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h00000000);

    // divide by zero keeps HI/LO
    hi_we = 1'b1; wdata = 32'h11111111;
    step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22222222;
    step();
    lo_we = 1'b0;
    chk("mthi", hi, 32'h11111111);
    chk("mtlo", lo, 32'h22222222);
    issue(2'b11, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_cycles", 32'(n), 32'd10);
    chk("div0_hi", hi, 32'h11111111);
    chk("div0_lo", lo, 32'h22222222);

    // requests while busy are ignored
    issue(2'b00, 32'd3, 32'd5);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    step();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("ign_nowr_hi", hi, 32'h11111111);
    wait_idle(n);
    chk("ign_cycles", 32'(n), 32'd4);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);
    lo_we = 1'b1; wdata = 32'hDEADBEEF;
    step();
    lo_we = 1'b0;
    chk("mtlo_after_lo", lo, 32'hDEADBEEF);
    chk("mtlo_after_hi", hi, 32'd0);

    // back-to-back issue
    issue(2'b01, 32'd3, 32'd4);
    wait_idle(n);
    chk("b2b_mul_cycles", 32'(n), 32'd5);
    chk("b2b_mul_lo", lo, 32'd12);
    chk("b2b_mul_hi", hi, 32'd0);
    issue(2'b11, 32'd100, 32'd7);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_div_cycles", 32'(n), 32'd10);
    chk("b2b_div_lo", lo, 32'd14);
    chk("b2b_div_hi", hi, 32'd2);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
